// File: rtl/id_stage_pipe.sv
// Decode stage: register file, load-use / write-back hazard detection and the ID/EX pipeline register.
// Define ID_WB_BYPASS_EN to forward the Wr-stage write data to same-cycle reads instead of stalling.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] busW,
    input  logic [REG_AW-1:0] Rw_Wr,
    input  logic              RegWr_Wr,
    input  logic              OverFlow_Wr,
    input  logic              Jal_Wr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic [REG_AW-1:0] dst_ID,
    input  logic              regwr_ID,
    input  logic              memrd_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [15:0]       imm16_ID,
    input  logic [25:0]       J_Target_ID,
    input  logic [31:0]       PC_Addr_ID,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              valid_EX,
    output logic [DATA_W-1:0] busA_EX,
    output logic [DATA_W-1:0] busB_EX,
    output logic [REG_AW-1:0] Rs_EX,
    output logic [REG_AW-1:0] Rt_EX,
    output logic [REG_AW-1:0] dst_EX,
    output logic              regwr_EX,
    output logic              memrd_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [15:0]       imm16_EX,
    output logic [31:0]       PC_EX,
    output logic [31:0]       J_Addr_EX
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] rf_q [NREG];
    logic              wrActive;
    logic [REG_AW-1:0] wrAddr;
    logic [DATA_W-1:0] rdA, rdB;
    logic              wbHazard;
    logic              loadUse;
    logic              valid_d;
    logic              loadEn;

    logic              valid_q;
    logic [DATA_W-1:0] busA_q, busB_q;
    logic [REG_AW-1:0] rs_q, rt_q, dst_q;
    logic              regwr_q, memrd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       imm16_q;
    logic [31:0]       pc_q, jAddr_q;

    // Overflowed results never commit; Jal links into the top register.
    assign wrActive = RegWr_Wr & ~OverFlow_Wr;
    assign wrAddr   = Jal_Wr ? {REG_AW{1'b1}} : Rw_Wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wrActive && (wrAddr != '0)) begin
            rf_q[wrAddr] <= busW;
        end
    end

    always_comb begin
        rdA = (Rs_ID == '0) ? '0 : rf_q[Rs_ID];
        rdB = (Rt_ID == '0) ? '0 : rf_q[Rt_ID];
`ifdef ID_WB_BYPASS_EN
        wbHazard = 1'b0;
        if (wrActive && (wrAddr != '0) && (wrAddr == Rs_ID)) rdA = busW;
        if (wrActive && (wrAddr != '0) && (wrAddr == Rt_ID)) rdB = busW;
`else
        wbHazard = in_valid & wrActive & (wrAddr != '0) &
                   ((wrAddr == Rs_ID) | (wrAddr == Rt_ID));
`endif
    end

    assign loadUse  = in_valid & valid_q & memrd_q & regwr_q & (dst_q != '0) &
                      ((dst_q == Rs_ID) | (dst_q == Rt_ID));
    assign in_ready = ex_ready & ~loadUse & ~wbHazard;

    // Flush beats everything; a stalled EX freezes the register; otherwise issue or bubble.
    always_comb begin
        valid_d = valid_q;
        loadEn  = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_ready) begin
            if (in_valid && in_ready) begin
                valid_d = 1'b1;
                loadEn  = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            busA_q  <= '0;
            busB_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            regwr_q <= 1'b0;
            memrd_q <= 1'b0;
            ctrl_q  <= '0;
            imm16_q <= '0;
            pc_q    <= '0;
            jAddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (loadEn) begin
                busA_q  <= rdA;
                busB_q  <= rdB;
                rs_q    <= Rs_ID;
                rt_q    <= Rt_ID;
                dst_q   <= dst_ID;
                regwr_q <= regwr_ID;
                memrd_q <= memrd_ID;
                ctrl_q  <= ctrl_ID;
                imm16_q <= imm16_ID;
                pc_q    <= PC_Addr_ID;
                jAddr_q <= {PC_Addr_ID[31:28], J_Target_ID, 2'b00};
            end
        end
    end

    assign valid_EX  = valid_q;
    assign busA_EX   = busA_q;
    assign busB_EX   = busB_q;
    assign Rs_EX     = rs_q;
    assign Rt_EX     = rt_q;
    assign dst_EX    = dst_q;
    assign regwr_EX  = regwr_q;
    assign memrd_EX  = memrd_q;
    assign ctrl_EX   = ctrl_q;
    assign imm16_EX  = imm16_q;
    assign PC_EX     = pc_q;
    assign J_Addr_EX = jAddr_q;

endmodule
